usb_tx_arbiter: RTL and testbench

USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

---
 rtl/usb_pkg.sv | 6 +
 rtl/usb_rr_arb.sv | 21 ++
 rtl/usb_tx_arbiter.sv | 90 +++++++++
 tb/tb_usb_tx_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared constants and FSM encoding for the USB TX arbiter.
package usb_pkg;
    localparam logic [7:0] HDR_BASE      = 8'hA0;
    localparam int         MAX_BURST_DEF = 64;
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, TRL} state_t;
endpackage

// File: rtl/usb_rr_arb.sv
// usb_rr_arb: combinational round-robin picker; search starts one past i_last_grant.
module usb_rr_arb #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] i_req,
    input  logic [1:0]     i_last_grant,
    output logic [1:0]     o_grant,
    output logic           o_any
);
    logic [1:0] w_idx;
    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        for (int i = NCH; i >= 1; i--) begin
            w_idx = 2'((int'(i_last_grant) + i) % NCH);
            if (i_req[w_idx]) o_grant = w_idx;
        end
    end
    assign o_any = |i_req;
endmodule

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: frames per-channel byte streams into header/payload/trailer packets for the USB TX FIFO.
// Define USB_TX_PRIO0_EN to give channel 0 strict priority over round-robin.
module usb_tx_arbiter
    import usb_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic             usb_clk_60m,
    input  logic             sys_rst,
    input  logic [NCH-1:0]   req_valid,
    input  logic [NCH*8-1:0] req_data,
    input  logic [NCH-1:0]   req_last,
    output logic [NCH-1:0]   req_ready,
    output logic             fifo_wr_en,
    output logic [7:0]       fifo_wr_data,
    input  logic             fifo_full,
    output logic             busy,
    output logic [1:0]       grant_id
);
    state_t     r_state;
    logic [6:0] r_cnt;
    logic [1:0] r_last_grant;
    logic [1:0] r_grant;
    logic [1:0] w_rr_grant;
    logic [1:0] w_win;
    logic       w_any;
    logic       w_sel_valid;
    logic       w_sel_last;
    logic [7:0] w_sel_data;
    logic       w_xfer;
    logic [6:0] w_cnt_nx;
    logic       w_end;

    usb_rr_arb #(.NCH(NCH)) u_rr (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_rr_grant),
        .o_any        (w_any)
    );

`ifdef USB_TX_PRIO0_EN
    assign w_win = req_valid[0] ? 2'd0 : w_rr_grant;
`else
    assign w_win = w_rr_grant;
`endif

    assign w_sel_valid = req_valid[r_grant];
    assign w_sel_last  = req_last[r_grant];
    assign w_sel_data  = req_data[8*r_grant +: 8];
    assign w_xfer      = (r_state == PAYLOAD) && w_sel_valid && !fifo_full;
    assign w_cnt_nx    = r_cnt + 7'd1;
    // A last byte landing exactly on the burst limit still closes with one trailer.
    assign w_end       = w_sel_last || (w_cnt_nx == 7'(MAX_BURST));

    always_ff @(posedge usb_clk_60m or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= 2'(NCH - 1);
            r_grant      <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_grant      <= w_win;
                    r_last_grant <= w_win;
                    r_cnt        <= '0;
                    r_state      <= HDR;
                end
                HDR: if (!fifo_full) r_state <= PAYLOAD;
                PAYLOAD: if (w_xfer) begin
                    r_cnt <= w_cnt_nx;
                    if (w_end) r_state <= TRL;
                end
                TRL: if (!fifo_full) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Write strobes depend on fifo_full directly so no byte is pushed into a full FIFO.
    assign busy         = r_state != IDLE;
    assign grant_id     = r_grant;
    assign fifo_wr_en   = (r_state == HDR || r_state == TRL) ? !fifo_full : w_xfer;
    assign fifo_wr_data = (r_state == HDR) ? (HDR_BASE | {6'b0, r_grant}) :
                          (r_state == TRL) ? {1'b0, r_cnt} :
                          w_xfer           ? w_sel_data : 8'h00;
    assign req_ready    = (r_state == PAYLOAD && !fifo_full) ?
                          ({{(NCH-1){1'b0}}, 1'b1} << r_grant) : '0;
endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb_usb_tx_arbiter: directed checks of framing, round-robin, burst split, stall and reset.
module tb_usb_tx_arbiter;
    localparam int NCH = 4;

    logic             usb_clk_60m = 1'b0;
    logic             sys_rst     = 1'b1;
    logic [NCH-1:0]   req_valid   = '0;
    logic [NCH*8-1:0] req_data    = '0;
    logic [NCH-1:0]   req_last    = '0;
    logic [NCH-1:0]   req_ready;
    logic             fifo_wr_en;
    logic [7:0]       fifo_wr_data;
    logic             fifo_full   = 1'b0;
    logic             busy;
    logic [1:0]       grant_id;

    logic [8:0]     q [NCH][$];
    logic [NCH-1:0] hs = '0;
    logic [7:0]     cap [$];
    logic [7:0]     exp_q [$];
    logic           full_nx = 1'b0;
    int n_chk = 0, n_fail = 0, n_full_wr = 0, n_full_rdy = 0;

    always #5 usb_clk_60m = ~usb_clk_60m;

    usb_tx_arbiter #(.NCH(NCH), .MAX_BURST(4)) dut (
        .usb_clk_60m  (usb_clk_60m),
        .sys_rst      (sys_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    task automatic step;
        @(posedge usb_clk_60m);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (hs[c]) void'(q[c].pop_front());
            req_valid[c] = q[c].size() > 0;
            req_data[c*8 +: 8] = (q[c].size() > 0) ? q[c][0][7:0] : 8'h00;
            req_last[c] = (q[c].size() > 0) ? q[c][0][8] : 1'b0;
        end
        hs = '0;
        fifo_full = full_nx;
        @(negedge usb_clk_60m);
        if (fifo_wr_en) cap.push_back(fifo_wr_data);
        if (fifo_full && fifo_wr_en) n_full_wr++;
        if (fifo_full && |req_ready) n_full_rdy++;
        hs = req_valid & req_ready;
    endtask

    function automatic bit drained();
        bit e = 1'b1;
        for (int c = 0; c < NCH; c++) if (q[c].size() != 0) e = 1'b0;
        return e && hs == '0 && !busy;
    endfunction

    task automatic do_reset;
        sys_rst = 1'b1;
        full_nx = 1'b0;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        hs = '0;
        for (int c = 0; c < NCH; c++) q[c].delete();
        cap.delete();
        repeat (2) @(posedge usb_clk_60m);
        @(negedge usb_clk_60m);
        sys_rst = 1'b0;
    endtask

    task automatic run_drain(input string name);
        int n = 0;
        step;
        while (!drained() && n < 100) begin
            step;
            n++;
        end
        n_chk++;
        if (!drained()) begin
            n_fail++;
            $display("FAIL %s_drain: busy=%0b not idle, required idle within 100 cycles", name, busy);
        end
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        req_valid = '1;
        @(negedge usb_clk_60m);
        n_chk += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy); end
        if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got %0b want 0", fifo_wr_en); end
        if (fifo_wr_data !== 8'h00) begin n_fail++; $display("FAIL rst_wr_data got %h want 00", fifo_wr_data); end
        if (req_ready !== 4'h0) begin n_fail++; $display("FAIL rst_ready got %h want 0", req_ready); end
        if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant got %0d want 0", grant_id); end
    endtask

    task automatic test_single;
        do_reset;
        q[1].push_back(9'h011);
        q[1].push_back(9'h022);
        q[1].push_back(9'h133);
        exp_q = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'h03};
        run_drain("single");
        n_chk++;
        if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL single_len got %0d want %0d", cap.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_chk++;
            if (cap[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_byte%0d got %h want %h", i, cap[i], exp_q[i]); end
        end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got %0b want 0", busy); end
    endtask

    task automatic test_round_robin;
        do_reset;
        q[0].push_back(9'h110);
        q[0].push_back(9'h150);
        q[1].push_back(9'h120);
        q[2].push_back(9'h130);
        q[3].push_back(9'h140);
        exp_q = '{8'hA0, 8'h10, 8'h01, 8'hA1, 8'h20, 8'h01, 8'hA2, 8'h30, 8'h01,
                  8'hA3, 8'h40, 8'h01, 8'hA0, 8'h50, 8'h01};
        run_drain("rr");
        n_chk++;
        if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL rr_len got %0d want %0d", cap.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_chk++;
            if (cap[i] !== exp_q[i]) begin n_fail++; $display("FAIL rr_byte%0d got %h want %h", i, cap[i], exp_q[i]); end
        end
    endtask

    task automatic test_split;
        do_reset;
        for (int i = 1; i <= 6; i++) q[2].push_back({i == 6, 8'(i)});
        exp_q = '{8'hA2, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'hA2, 8'h05, 8'h06, 8'h02};
        run_drain("split");
        n_chk++;
        if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL split_len got %0d want %0d", cap.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_chk++;
            if (cap[i] !== exp_q[i]) begin n_fail++; $display("FAIL split_byte%0d got %h want %h", i, cap[i], exp_q[i]); end
        end
    endtask

    task automatic test_exact_burst;
        do_reset;
        for (int i = 1; i <= 4; i++) q[3].push_back({i == 4, 8'hA0 + 8'(i)});
        exp_q = '{8'hA3, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h04};
        run_drain("exact");
        repeat (3) step;
        n_chk++;
        if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL exact_len got %0d want %0d", cap.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_chk++;
            if (cap[i] !== exp_q[i]) begin n_fail++; $display("FAIL exact_byte%0d got %h want %h", i, cap[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall;
        int n = 0;
        do_reset;
        q[0].push_back(9'h0C1);
        q[0].push_back(9'h0C2);
        q[0].push_back(9'h1C3);
        while (cap.size() < 2 && n < 20) begin step; n++; end
        full_nx = 1'b1;
        n_full_wr = 0;
        n_full_rdy = 0;
        repeat (5) step;
        n_chk += 4;
        if (n_full_wr != 0) begin n_fail++; $display("FAIL stall_wr_en got %0d writes want 0", n_full_wr); end
        if (n_full_rdy != 0) begin n_fail++; $display("FAIL stall_ready got %0d cycles want 0", n_full_rdy); end
        if (cap.size() != 2) begin n_fail++; $display("FAIL stall_count got %0d want 2", cap.size()); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy got %0b want 1", busy); end
        full_nx = 1'b0;
        exp_q = '{8'hA0, 8'hC1, 8'hC2, 8'hC3, 8'h03};
        run_drain("stall");
        n_chk++;
        if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_len got %0d want %0d", cap.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_chk++;
            if (cap[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_byte%0d got %h want %h", i, cap[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        do_reset;
        for (int i = 1; i <= 4; i++) q[1].push_back({i == 4, 8'hD0 + 8'(i)});
        while (cap.size() < 2 && n < 20) begin step; n++; end
        #1 sys_rst = 1'b1;
        #1;
        n_chk += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %0b want 0", busy); end
        if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_en got %0b want 0", fifo_wr_en); end
        if (fifo_wr_data !== 8'h00) begin n_fail++; $display("FAIL rmid_wr_data got %h want 00", fifo_wr_data); end
        if (req_ready !== 4'h0) begin n_fail++; $display("FAIL rmid_ready got %h want 0", req_ready); end
        do_reset;
        q[0].push_back(9'h15A);
        q[1].push_back(9'h16B);
        exp_q = '{8'hA0, 8'h5A, 8'h01, 8'hA1, 8'h6B, 8'h01};
        run_drain("rmid");
        n_chk++;
        if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL rmid_len got %0d want %0d", cap.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_chk++;
            if (cap[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_byte%0d got %h want %h", i, cap[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        q[0].push_back(9'h171);
        q[0].push_back(9'h172);
        q[3].push_back(9'h181);
        q[3].push_back(9'h182);
        exp_q = '{8'hA0, 8'h71, 8'h01, 8'hA3, 8'h81, 8'h01, 8'hA0, 8'h72, 8'h01, 8'hA3, 8'h82, 8'h01};
        run_drain("b2b");
        n_chk++;
        if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_len got %0d want %0d", cap.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_chk++;
            if (cap[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d got %h want %h", i, cap[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_split;
        test_exact_burst;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
